frame_buf_sched: RTL and testbench

//  Sequences the 3-slot luma/bit-plane frame store written by gcbp and read by the motion estimator (ME).

---
 rtl/frame_buf_sched_pkg.sv | 20 ++
 rtl/frame_slot_rotator.sv | 43 ++++
 rtl/frame_buf_sched.sv | 146 ++++++++++++++
 tb/tb_frame_buf_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_sched_pkg.sv
// Shared types and constants for the frame store sequencer: slot index width,
// reset slot assignment and the frame sequencing state encoding.
package frame_buf_sched_pkg;

   localparam int SLOT_W = 2;

   localparam logic [SLOT_W-1:0] SLOT_NEXT_RST = 2'd0;
   localparam logic [SLOT_W-1:0] SLOT_CURR_RST = 2'd1;
   localparam logic [SLOT_W-1:0] SLOT_PREV_RST = 2'd2;

   // Complete frames needed in curr/prev before the ME may be started.
   localparam logic [1:0] FILL_FRAMES = 2'd2;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2
   } fbs_state_t;

endpackage

// File: rtl/frame_slot_rotator.sv
// Slot pointer rotation for the 3-slot frame store, plus frame-start detection
// on the field flag and the post-reset fill counter.
module frame_slot_rotator
   import frame_buf_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              field_0,
   input  logic              rotate,
   input  logic              fill_inc,
   output logic              fs,
   output logic [SLOT_W-1:0] next_loc,
   output logic [SLOT_W-1:0] curr_loc,
   output logic [SLOT_W-1:0] prev_loc,
   output logic [1:0]        fill_cnt
);

   logic field_q;

   // field_q resets high so a field flag already high out of reset is not a frame start.
   assign fs = field_0 & ~field_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         field_q  <= 1'b1;
         next_loc <= SLOT_NEXT_RST;
         curr_loc <= SLOT_CURR_RST;
         prev_loc <= SLOT_PREV_RST;
         fill_cnt <= 2'd0;
      end else begin
         field_q <= field_0;
         if (rotate) begin
            prev_loc <= curr_loc;
            curr_loc <= next_loc;
            next_loc <= prev_loc;
         end
         if (fill_inc && (fill_cnt != FILL_FRAMES)) begin
            fill_cnt <= fill_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/frame_buf_sched.sv
// Frame store sequencer: rotates the next/curr/prev slots, starts the motion
// estimator on complete frame pairs, drops frames while it is busy, and
// arbitrates the shared BRAM port between the writer and ME reads.
module frame_buf_sched
   import frame_buf_sched_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 128,
   parameter int WE_W   = 16,
   parameter int DROP_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_resetn,
   input  logic                     i_field_0,
   input  logic                     i_wr_valid,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic [DATA_W-1:0]        i_wr_data,
   input  logic [WE_W-1:0]          i_wr_en,
   input  logic                     i_rd_req,
   input  logic                     i_rd_sel,
   input  logic [ADDR_W-1:0]        i_rd_addr,
   input  logic                     i_me_done,
   output logic [SLOT_W+ADDR_W-1:0] o_bram_addr,
   output logic [DATA_W-1:0]        o_bram_wdata,
   output logic [WE_W-1:0]          o_bram_we,
   output logic                     o_rd_grant,
   output logic                     o_rd_valid,
   output logic                     o_me_start,
   output logic [SLOT_W-1:0]        o_next_frame_loc,
   output logic [SLOT_W-1:0]        o_curr_frame_loc,
   output logic [SLOT_W-1:0]        o_prev_frame_loc,
   output logic                     o_drop,
   output logic [DROP_W-1:0]        o_drop_cnt,
   output logic [1:0]               o_state
);

   fbs_state_t        state;
   logic              fs;
   logic              rotate;
   logic              fill_inc;
   logic [1:0]        fill_cnt;
   logic [SLOT_W-1:0] rd_slot;
   logic              grant_d1;

   frame_slot_rotator u_rotator (
      .clk      (i_clk),
      .rst_n    (i_resetn),
      .field_0  (i_field_0),
      .rotate   (rotate),
      .fill_inc (fill_inc),
      .fs       (fs),
      .next_loc (o_next_frame_loc),
      .curr_loc (o_curr_frame_loc),
      .prev_loc (o_prev_frame_loc),
      .fill_cnt (fill_cnt)
   );

   assign o_state = state;

   // In RUN a frame start only rotates when the ME finishes in the same cycle;
   // otherwise the frame is dropped and the writer overwrites next.
   always_comb begin
      rotate   = 1'b0;
      fill_inc = 1'b0;
      case (state)
         ST_FILL: begin
            rotate   = fs;
            fill_inc = fs;
         end
         ST_IDLE: rotate = fs;
         ST_RUN:  rotate = fs & i_me_done;
         default: rotate = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state      <= ST_FILL;
         o_me_start <= 1'b0;
         o_drop     <= 1'b0;
         o_drop_cnt <= '0;
      end else begin
         o_me_start <= 1'b0;
         o_drop     <= 1'b0;
         case (state)
            ST_FILL: begin
               if (fs && (fill_cnt == FILL_FRAMES - 2'd1)) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (fs) begin
                  o_me_start <= 1'b1;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (i_me_done && fs) begin
                  o_me_start <= 1'b1;
               end else if (i_me_done) begin
                  state <= ST_IDLE;
               end else if (fs) begin
                  o_drop <= 1'b1;
                  if (o_drop_cnt != {DROP_W{1'b1}}) begin
                     o_drop_cnt <= o_drop_cnt + DROP_W'(1);
                  end
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

   assign rd_slot = i_rd_sel ? o_prev_frame_loc : o_curr_frame_loc;

   // Read handshake: the ME holds i_rd_req (with sel/addr stable) until it sees
   // o_rd_grant; the granted cycle carries its address, data follows 2 cycles later.
   // The writer has strict priority and is never stalled.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_bram_addr  <= '0;
         o_bram_wdata <= '0;
         o_bram_we    <= '0;
         o_rd_grant   <= 1'b0;
         grant_d1     <= 1'b0;
         o_rd_valid   <= 1'b0;
      end else begin
         grant_d1   <= o_rd_grant;
         o_rd_valid <= grant_d1;
         if (i_wr_valid) begin
            o_bram_addr  <= {o_next_frame_loc, i_wr_addr};
            o_bram_wdata <= i_wr_data;
            o_bram_we    <= i_wr_en;
            o_rd_grant   <= 1'b0;
         end else if (i_rd_req) begin
            o_bram_addr <= {rd_slot, i_rd_addr};
            o_bram_we   <= '0;
            o_rd_grant  <= 1'b1;
         end else begin
            o_bram_we  <= '0;
            o_rd_grant <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed self-checking bench for frame_buf_sched: slot rotation, ME start,
// frame drop and saturation, writer/reader arbitration and mid-run reset.
module tb_frame_buf_sched;

   logic         clk;
   logic         resetn;
   logic         field_0;
   logic         wr_valid;
   logic [8:0]   wr_addr;
   logic [127:0] wr_data;
   logic [15:0]  wr_en;
   logic         rd_req;
   logic         rd_sel;
   logic [8:0]   rd_addr;
   logic         me_done;
   logic [10:0]  bram_addr;
   logic [127:0] bram_wdata;
   logic [15:0]  bram_we;
   logic         rd_grant;
   logic         rd_valid;
   logic         me_start;
   logic [1:0]   next_loc;
   logic [1:0]   curr_loc;
   logic [1:0]   prev_loc;
   logic         drop;
   logic [7:0]   drop_cnt;
   logic [1:0]   state;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [1:0] S_FILL = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   frame_buf_sched dut (
      .i_clk            (clk),
      .i_resetn         (resetn),
      .i_field_0        (field_0),
      .i_wr_valid       (wr_valid),
      .i_wr_addr        (wr_addr),
      .i_wr_data        (wr_data),
      .i_wr_en          (wr_en),
      .i_rd_req         (rd_req),
      .i_rd_sel         (rd_sel),
      .i_rd_addr        (rd_addr),
      .i_me_done        (me_done),
      .o_bram_addr      (bram_addr),
      .o_bram_wdata     (bram_wdata),
      .o_bram_we        (bram_we),
      .o_rd_grant       (rd_grant),
      .o_rd_valid       (rd_valid),
      .o_me_start       (me_start),
      .o_next_frame_loc (next_loc),
      .o_curr_frame_loc (curr_loc),
      .o_prev_frame_loc (prev_loc),
      .o_drop           (drop),
      .o_drop_cnt       (drop_cnt),
      .o_state          (state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
   task automatic fs_pulse(input logic done);
      field_0 = 1'b1;
      me_done = done;
      @(negedge clk);
      field_0 = 1'b0;
      me_done = 1'b0;
   endtask

   task automatic done_pulse();
      me_done = 1'b1;
      @(negedge clk);
      me_done = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1; field_0 = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      wr_en = '0; rd_req = 1'b0; rd_sel = 1'b0; rd_addr = '0; me_done = 1'b0;
      #2 resetn = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({next_loc, curr_loc, prev_loc} !== {2'd0, 2'd1, 2'd2}) begin
         n_err++; $display("FAIL reset_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc}, {2'd0, 2'd1, 2'd2}); end
      n_cmp++; if (state !== S_FILL) begin n_err++; $display("FAIL reset_state: got %0d required %0d", state, S_FILL); end
      n_cmp++; if ({bram_addr, bram_we, rd_grant, rd_valid} !== '0) begin
         n_err++; $display("FAIL reset_port: addr %h we %h grant %b valid %b required all 0", bram_addr, bram_we, rd_grant, rd_valid); end
      n_cmp++; if (bram_wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h required 0", bram_wdata); end
      n_cmp++; if ({me_start, drop, drop_cnt} !== '0) begin
         n_err++; $display("FAIL reset_pulses: start %b drop %b cnt %0d required 0", me_start, drop, drop_cnt); end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if ({state, me_start} !== {S_FILL, 1'b0}) begin
         n_err++; $display("FAIL reset_release: state %0d start %b required FILL/0", state, me_start); end
   endtask

   task automatic test_fill();
      fs_pulse(1'b0);
      n_cmp++; if ({next_loc, curr_loc, prev_loc} !== {2'd2, 2'd0, 2'd1}) begin
         n_err++; $display("FAIL fill1_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc}, {2'd2, 2'd0, 2'd1}); end
      n_cmp++; if ({state, me_start} !== {S_FILL, 1'b0}) begin
         n_err++; $display("FAIL fill1_state: state %0d start %b required FILL/0", state, me_start); end
      @(negedge clk);
      fs_pulse(1'b0);
      n_cmp++; if ({next_loc, curr_loc, prev_loc} !== {2'd1, 2'd2, 2'd0}) begin
         n_err++; $display("FAIL fill2_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc}, {2'd1, 2'd2, 2'd0}); end
      n_cmp++; if ({state, me_start} !== {S_IDLE, 1'b0}) begin
         n_err++; $display("FAIL fill2_state: state %0d start %b required IDLE/0", state, me_start); end
      @(negedge clk);
   endtask

   task automatic test_start();
      fs_pulse(1'b0);
      n_cmp++; if (me_start !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b required 1", me_start); end
      n_cmp++; if ({next_loc, curr_loc, prev_loc, state} !== {2'd0, 2'd1, 2'd2, S_RUN}) begin
         n_err++; $display("FAIL start_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc, state}, {2'd0, 2'd1, 2'd2, S_RUN}); end
      @(negedge clk);
      n_cmp++; if (me_start !== 1'b0) begin n_err++; $display("FAIL start_width: got %b required 0", me_start); end
   endtask

   task automatic test_drop();
      fs_pulse(1'b0);
      n_cmp++; if ({drop, drop_cnt, me_start} !== {1'b1, 8'd1, 1'b0}) begin
         n_err++; $display("FAIL drop_pulse: drop %b cnt %0d start %b required 1/1/0", drop, drop_cnt, me_start); end
      n_cmp++; if ({next_loc, curr_loc, prev_loc, state} !== {2'd0, 2'd1, 2'd2, S_RUN}) begin
         n_err++; $display("FAIL drop_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc, state}, {2'd0, 2'd1, 2'd2, S_RUN}); end
      @(negedge clk);
      n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL drop_width: got %b required 0", drop); end
   endtask

   task automatic test_done_and_fs();
      fs_pulse(1'b1);
      n_cmp++; if ({me_start, drop, drop_cnt} !== {1'b1, 1'b0, 8'd1}) begin
         n_err++; $display("FAIL donefs_pulse: start %b drop %b cnt %0d required 1/0/1", me_start, drop, drop_cnt); end
      n_cmp++; if ({next_loc, curr_loc, prev_loc, state} !== {2'd2, 2'd0, 2'd1, S_RUN}) begin
         n_err++; $display("FAIL donefs_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc, state}, {2'd2, 2'd0, 2'd1, S_RUN}); end
      @(negedge clk);
   endtask

   // Pointers here: next=2 curr=0 prev=1
   task automatic test_arbiter();
      rd_req = 1'b1; rd_sel = 1'b0; rd_addr = 9'h055;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1;
         wr_addr  = 9'h010 + 9'(i);
         wr_data  = {4{32'hA5A5_0000 + 32'(i)}};
         wr_en    = 16'hF0F0 ^ 16'(i);
         @(negedge clk);
         n_cmp++; if ({rd_grant, rd_valid, bram_addr, bram_we} !== {1'b0, 1'b0, 2'd2, 9'h010 + 9'(i), 16'hF0F0 ^ 16'(i)}) begin
            n_err++; $display("FAIL arb_write%0d: grant %b valid %b addr %h we %h required 0/0/%h/%h", i, rd_grant, rd_valid,
               bram_addr, bram_we, {2'd2, 9'h010 + 9'(i)}, 16'hF0F0 ^ 16'(i)); end
         n_cmp++; if (bram_wdata !== {4{32'hA5A5_0000 + 32'(i)}}) begin
            n_err++; $display("FAIL arb_wdata%0d: got %h required %h", i, bram_wdata, {4{32'hA5A5_0000 + 32'(i)}}); end
      end
      wr_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({rd_grant, bram_addr, bram_we} !== {1'b1, 2'd0, 9'h055, 16'h0000}) begin
         n_err++; $display("FAIL arb_grant: grant %b addr %h we %h required 1/%h/0", rd_grant, bram_addr, bram_we, {2'd0, 9'h055}); end
      rd_req = 1'b0;
      @(negedge clk);
      n_cmp++; if ({rd_grant, rd_valid, bram_addr} !== {1'b0, 1'b0, 2'd0, 9'h055}) begin
         n_err++; $display("FAIL arb_hold: grant %b valid %b addr %h required 0/0/%h", rd_grant, rd_valid, bram_addr, {2'd0, 9'h055}); end
      @(negedge clk);
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL arb_rd_valid: got %b required 1", rd_valid); end
      rd_req = 1'b1; rd_sel = 1'b1; rd_addr = 9'h1AB;
      @(negedge clk);
      rd_req = 1'b0;
      n_cmp++; if ({rd_valid, rd_grant, bram_addr} !== {1'b0, 1'b1, 2'd1, 9'h1AB}) begin
         n_err++; $display("FAIL arb_prev_read: valid %b grant %b addr %h required 0/1/%h", rd_valid, rd_grant, bram_addr, {2'd1, 9'h1AB}); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_done_ignored();
      done_pulse();
      n_cmp++; if (state !== S_IDLE) begin n_err++; $display("FAIL done_to_idle: got %0d required %0d", state, S_IDLE); end
      done_pulse();
      n_cmp++; if ({state, me_start} !== {S_IDLE, 1'b0}) begin
         n_err++; $display("FAIL done_in_idle: state %0d start %b required IDLE/0", state, me_start); end
      fs_pulse(1'b0);
      n_cmp++; if ({me_start, next_loc, curr_loc, prev_loc} !== {1'b1, 2'd1, 2'd2, 2'd0}) begin
         n_err++; $display("FAIL restart: got %h required %h", {me_start, next_loc, curr_loc, prev_loc}, {1'b1, 2'd1, 2'd2, 2'd0}); end
      @(negedge clk);
   endtask

   task automatic test_drop_saturate();
      for (int i = 0; i < 260; i++) begin
         fs_pulse(1'b0);
         @(negedge clk);
         if (i == 253) begin
            n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_reach_max: got %0d required 255", drop_cnt); end
         end
      end
      fs_pulse(1'b0);
      n_cmp++; if ({drop, drop_cnt} !== {1'b1, 8'd255}) begin
         n_err++; $display("FAIL drop_saturate: drop %b cnt %0d required 1/255", drop, drop_cnt); end
      n_cmp++; if ({next_loc, curr_loc, prev_loc, state} !== {2'd1, 2'd2, 2'd0, S_RUN}) begin
         n_err++; $display("FAIL drop_sat_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc, state}, {2'd1, 2'd2, 2'd0, S_RUN}); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      rd_req = 1'b1; rd_sel = 1'b0; rd_addr = 9'h0AA;
      @(negedge clk);
      n_cmp++; if ({rd_grant, bram_addr} !== {1'b1, 2'd2, 9'h0AA}) begin
         n_err++; $display("FAIL midrst_grant: grant %b addr %h required 1/%h", rd_grant, bram_addr, {2'd2, 9'h0AA}); end
      resetn = 1'b0;
      #1;
      n_cmp++; if ({bram_addr, bram_we, rd_grant, rd_valid, me_start, drop, drop_cnt} !== '0) begin
         n_err++; $display("FAIL midrst_outputs: addr %h we %h grant %b valid %b start %b drop %b cnt %0d required all 0",
            bram_addr, bram_we, rd_grant, rd_valid, me_start, drop, drop_cnt); end
      n_cmp++; if ({next_loc, curr_loc, prev_loc, state} !== {2'd0, 2'd1, 2'd2, S_FILL}) begin
         n_err++; $display("FAIL midrst_ptrs: got %h required %h", {next_loc, curr_loc, prev_loc, state}, {2'd0, 2'd1, 2'd2, S_FILL}); end
      rd_req = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      fs_pulse(1'b0);
      n_cmp++; if ({me_start, state} !== {1'b0, S_FILL}) begin
         n_err++; $display("FAIL refill1: start %b state %0d required 0/FILL", me_start, state); end
      @(negedge clk);
      fs_pulse(1'b0);
      n_cmp++; if ({me_start, state} !== {1'b0, S_IDLE}) begin
         n_err++; $display("FAIL refill2: start %b state %0d required 0/IDLE", me_start, state); end
      @(negedge clk);
      fs_pulse(1'b0);
      n_cmp++; if ({me_start, state, next_loc, curr_loc, prev_loc} !== {1'b1, S_RUN, 2'd0, 2'd1, 2'd2}) begin
         n_err++; $display("FAIL refill_start: got %h required %h", {me_start, state, next_loc, curr_loc, prev_loc},
            {1'b1, S_RUN, 2'd0, 2'd1, 2'd2}); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_start();
      test_drop();
      test_done_and_fs();
      test_arbiter();
      test_done_ignored();
      test_drop_saturate();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
